// File: rtl/fft_bin_rotator.sv
// fft_bin_rotator
//   Per-bin complex rotator placed between the FFT core and the spectrum
//   buffer. Each accepted bin X[n] is multiplied by the phasor P[n] read from
//   an external coefficient RAM, either as X*P or as X*conj(P). Rotation only
//   engages and disengages on frame boundaries. Results are rounded half-up
//   and saturated. A frame-length checker runs continuously.
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   i_mode              operating mode (MODE_ROT / MODE_CONJ engage)
//   i_FFT_*             input bin stream (valid strobe, gaps allowed, last)
//   o_ram_rotate_addr   coefficient RAM address = index of next expected bin
//   i_phase_cos/sin     RAM read data, valid COEF_LAT cycles after addressing
//   o_rotate_*          rotated output stream (COEF_LAT+3 cycle latency)
//   o_len_err           1-cycle pulse on frame-length mismatch
//   o_busy              engaged or finishing (ARM/WORK/DRAIN)
module fft_bin_rotator #(
  parameter int         FFT_POINT  = 8192,
  parameter int         ADDR_WIDTH = 14,
  parameter int         DATA_W     = 16,
  parameter int         COEF_W     = 16,
  parameter int         COEF_LAT   = 1,
  parameter logic [7:0] MODE_ROT   = 8'd4,
  parameter logic [7:0] MODE_CONJ  = 8'd5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_mode,
  input  logic [DATA_W-1:0]     i_FFT_I_data,
  input  logic [DATA_W-1:0]     i_FFT_Q_data,
  input  logic                  i_FFT_valid,
  input  logic                  i_FFT_last,
  output logic [ADDR_WIDTH-1:0] o_ram_rotate_addr,
  input  logic [COEF_W-1:0]     i_phase_cos,
  input  logic [COEF_W-1:0]     i_phase_sin,
  output logic [DATA_W-1:0]     o_rotate_I_data,
  output logic [DATA_W-1:0]     o_rotate_Q_data,
  output logic                  o_rotate_valid,
  output logic                  o_rotate_last,
  output logic                  o_len_err,
  output logic                  o_busy
);

  localparam int PW = DATA_W + COEF_W;       // product width
  localparam int SW = PW + 1;                // full-precision sum width
  localparam int RW = DATA_W + 2;            // rounded, pre-saturation width
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_IDX = ADDR_WIDTH'(FFT_POINT - 1);
  localparam logic signed [SW-1:0]  LP_RND = SW'(1) <<< (COEF_W - 2);
  localparam logic signed [RW-1:0]  LP_MAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [RW-1:0]  LP_MIN = {3'b111, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WORK, S_DRAIN} state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_len_err;
  logic                  r_conj;
  logic                  r_drain_done;

  logic w_accept, w_at_end, w_boundary;
  logic w_mode_rot, w_mode_conj, w_mode_ok;
  logic w_frame_gap;
  logic w_emit;
  logic w_pipe_busy;

  // Pipeline storage
  logic                     r_al_v    [COEF_LAT];
  logic                     r_al_last [COEF_LAT];
  logic                     r_al_conj [COEF_LAT];
  logic signed [DATA_W-1:0] r_al_i    [COEF_LAT];
  logic signed [DATA_W-1:0] r_al_q    [COEF_LAT];

  logic                 r_s1_v, r_s1_last, r_s1_conj;
  logic signed [PW-1:0] r_p_ic, r_p_qs, r_p_is, r_p_qc;
  logic                 r_s2_v, r_s2_last;
  logic signed [RW-1:0] r_s2_i, r_s2_q;
  logic                 r_out_v, r_out_last;
  logic [DATA_W-1:0]    r_out_i, r_out_q;

  logic signed [COEF_W-1:0] w_cos, w_sin;
  logic signed [SW-1:0]     w_sum_i, w_sum_q, w_rnd_i, w_rnd_q;
  logic signed [RW-1:0]     w_rs_i, w_rs_q;
  logic [DATA_W-1:0]        w_sat_i, w_sat_q;

  assign w_accept    = i_FFT_valid;
  assign w_at_end    = (r_cnt == LP_LAST_IDX);
  assign w_boundary  = w_accept & (i_FFT_last | w_at_end);
  assign w_mode_rot  = (i_mode == MODE_ROT);
  assign w_mode_conj = (i_mode == MODE_CONJ);
  assign w_mode_ok   = w_mode_rot | w_mode_conj;
  // Between frames: counter at 0 and no beat arriving this cycle.
  assign w_frame_gap = (r_cnt == '0) & ~w_accept;

  // Frame tracking runs in every state so alignment is known before engaging.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (w_boundary)
        r_cnt <= '0;
      else if (w_accept)
        r_cnt <= r_cnt + ADDR_WIDTH'(1);
      r_len_err <= w_accept & (i_FFT_last ^ w_at_end);
    end
  end

  assign o_ram_rotate_addr = r_cnt;
  assign o_len_err         = r_len_err;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_mode_ok) w_next = S_ARM;
      S_ARM: begin
        if (!w_mode_ok)                      w_next = S_IDLE;
        else if (w_boundary || w_frame_gap)  w_next = S_WORK;
      end
      S_WORK:  if (!w_mode_ok) w_next = S_DRAIN;
      S_DRAIN: if (r_drain_done && !w_pipe_busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs. Beats of the frame in progress keep emitting in DRAIN
  // until its boundary beat has been accepted.
  always_comb begin
    w_emit = w_accept & ((r_state == S_WORK) | ((r_state == S_DRAIN) & ~r_drain_done));
    o_busy = (r_state != S_IDLE);
  end

  // Rotation sense is latched on entry to WORK and re-latched only at frame
  // boundaries; each beat carries its own copy, so a boundary re-latch never
  // affects beats already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conj       <= 1'b0;
      r_drain_done <= 1'b0;
    end else begin
      if ((w_next == S_WORK) && ((r_state != S_WORK) || w_boundary || w_frame_gap))
        r_conj <= w_mode_conj;
      if ((r_state == S_WORK) && (w_next == S_DRAIN))
        r_drain_done <= w_boundary;
      else if ((r_state == S_DRAIN) && w_boundary)
        r_drain_done <= 1'b1;
    end
  end

  always_comb begin
    w_pipe_busy = r_s1_v | r_s2_v | r_out_v;
    for (int unsigned k = 0; k < COEF_LAT; k++)
      w_pipe_busy = w_pipe_busy | r_al_v[k];
  end

  // Pipeline control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < COEF_LAT; k++) r_al_v[k] <= 1'b0;
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_out_v    <= 1'b0;
      r_out_last <= 1'b0;
      r_out_i    <= '0;
      r_out_q    <= '0;
    end else begin
      r_al_v[0] <= w_emit;
      for (int unsigned k = 1; k < COEF_LAT; k++) r_al_v[k] <= r_al_v[k-1];
      r_s1_v     <= r_al_v[COEF_LAT-1];
      r_s2_v     <= r_s1_v;
      r_out_v    <= r_s2_v;
      r_out_last <= r_s2_v & r_s2_last;
      if (r_s2_v) begin
        r_out_i <= w_sat_i;
        r_out_q <= w_sat_q;
      end
    end
  end

  assign w_cos = $signed(i_phase_cos);
  assign w_sin = $signed(i_phase_sin);

  // Datapath registers (no reset needed; qualified by the valid chain)
  always_ff @(posedge clk) begin
    r_al_i[0]    <= $signed(i_FFT_I_data);
    r_al_q[0]    <= $signed(i_FFT_Q_data);
    r_al_last[0] <= i_FFT_last;
    r_al_conj[0] <= r_conj;
    for (int unsigned k = 1; k < COEF_LAT; k++) begin
      r_al_i[k]    <= r_al_i[k-1];
      r_al_q[k]    <= r_al_q[k-1];
      r_al_last[k] <= r_al_last[k-1];
      r_al_conj[k] <= r_al_conj[k-1];
    end
    r_p_ic    <= PW'(r_al_i[COEF_LAT-1]) * PW'(w_cos);
    r_p_qs    <= PW'(r_al_q[COEF_LAT-1]) * PW'(w_sin);
    r_p_is    <= PW'(r_al_i[COEF_LAT-1]) * PW'(w_sin);
    r_p_qc    <= PW'(r_al_q[COEF_LAT-1]) * PW'(w_cos);
    r_s1_last <= r_al_last[COEF_LAT-1];
    r_s1_conj <= r_al_conj[COEF_LAT-1];
    r_s2_i    <= w_rs_i;
    r_s2_q    <= w_rs_q;
    r_s2_last <= r_s1_last;
  end

  // Sum, round half-up, shift back to data scale
  always_comb begin
    if (r_s1_conj) begin
      w_sum_i = SW'(r_p_ic) + SW'(r_p_qs);
      w_sum_q = SW'(r_p_qc) - SW'(r_p_is);
    end else begin
      w_sum_i = SW'(r_p_ic) - SW'(r_p_qs);
      w_sum_q = SW'(r_p_is) + SW'(r_p_qc);
    end
    w_rnd_i = w_sum_i + LP_RND;
    w_rnd_q = w_sum_q + LP_RND;
    w_rs_i  = RW'(w_rnd_i >>> (COEF_W - 1));
    w_rs_q  = RW'(w_rnd_q >>> (COEF_W - 1));
  end

  // Saturate
  always_comb begin
    if (r_s2_i > LP_MAX)      w_sat_i = DATA_W'(LP_MAX);
    else if (r_s2_i < LP_MIN) w_sat_i = DATA_W'(LP_MIN);
    else                      w_sat_i = DATA_W'(r_s2_i);
    if (r_s2_q > LP_MAX)      w_sat_q = DATA_W'(LP_MAX);
    else if (r_s2_q < LP_MIN) w_sat_q = DATA_W'(LP_MIN);
    else                      w_sat_q = DATA_W'(r_s2_q);
  end

  assign o_rotate_I_data = r_out_i;
  assign o_rotate_Q_data = r_out_q;
  assign o_rotate_valid  = r_out_v;
  assign o_rotate_last   = r_out_last;

endmodule

// File: tb/tb_fft_bin_rotator.sv
// tb_fft_bin_rotator
//   Directed bench for fft_bin_rotator. Acts as the coefficient RAM, keeps a
//   scoreboard of expected rotated beats and checks addressing, frame-length
//   errors, mode engagement/disengagement, saturation and reset behaviour.
module tb_fft_bin_rotator;

  localparam int FFT = 8192;
  localparam int AW  = 14;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    i_mode;
  logic [DW-1:0] i_FFT_I_data, i_FFT_Q_data;
  logic          i_FFT_valid, i_FFT_last;
  logic [AW-1:0] o_ram_rotate_addr;
  logic [CW-1:0] i_phase_cos, i_phase_sin;
  logic [DW-1:0] o_rotate_I_data, o_rotate_Q_data;
  logic          o_rotate_valid, o_rotate_last, o_len_err, o_busy;

  fft_bin_rotator #(
    .FFT_POINT(FFT), .ADDR_WIDTH(AW), .DATA_W(DW), .COEF_W(CW),
    .COEF_LAT(LAT), .MODE_ROT(8'd4), .MODE_CONJ(8'd5)
  ) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode),
    .i_FFT_I_data(i_FFT_I_data), .i_FFT_Q_data(i_FFT_Q_data),
    .i_FFT_valid(i_FFT_valid), .i_FFT_last(i_FFT_last),
    .o_ram_rotate_addr(o_ram_rotate_addr),
    .i_phase_cos(i_phase_cos), .i_phase_sin(i_phase_sin),
    .o_rotate_I_data(o_rotate_I_data), .o_rotate_Q_data(o_rotate_Q_data),
    .o_rotate_valid(o_rotate_valid), .o_rotate_last(o_rotate_last),
    .o_len_err(o_len_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic        last;
    longint      cyc;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;
  int     sel = 0;        // coefficient table selector
  int     bidx = 0;       // bench's own bin index
  bit     cur_conj = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int coef_c(int a, int s);
    case (s)
      0: return 32767;
      1: return 0;
      2: return -32768;
      default: return ((a * 7919 + 123) % 65536) - 32768;
    endcase
  endfunction

  function automatic int coef_s(int a, int s);
    case (s)
      0: return 0;
      1: return 32767;
      2: return 0;
      default: return ((a * 104729 + 777) % 65536) - 32768;
    endcase
  endfunction

  // Coefficient RAM with one cycle of read latency
  always @(posedge clk) begin
    i_phase_cos <= 16'(coef_c(int'(o_ram_rotate_addr), sel));
    i_phase_sin <= 16'(coef_s(int'(o_ram_rotate_addr), sel));
  end

  function automatic longint sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [31:0] model(int xi, int xq, int c, int s, bit cj);
    longint pi, pq, ri, rq;
    if (!cj) begin
      pi = longint'(xi) * c - longint'(xq) * s;
      pq = longint'(xi) * s + longint'(xq) * c;
    end else begin
      pi = longint'(xi) * c + longint'(xq) * s;
      pq = longint'(xq) * c - longint'(xi) * s;
    end
    ri = sat16((pi + (longint'(1) << (CW - 2))) >>> (CW - 1));
    rq = sat16((pq + (longint'(1) << (CW - 2))) >>> (CW - 1));
    return {16'(ri), 16'(rq)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One beat; called at posedge+1, returns at posedge+1.
  task automatic beat(input int xi, input int xq, input bit lst, input bit emit, input bit gaps);
    logic [31:0] r;
    bit exp_err;
    chk("addr", 64'(o_ram_rotate_addr), 64'(bidx));
    i_FFT_I_data = 16'(xi);
    i_FFT_Q_data = 16'(xq);
    i_FFT_valid  = 1'b1;
    i_FFT_last   = lst;
    if (emit) begin
      r = model(xi, xq, coef_c(bidx, sel), coef_s(bidx, sel), cur_conj);
      sb.push_back('{i: r[31:16], q: r[15:0], last: lst, cyc: cyc});
    end
    exp_err = (lst != (bidx == FFT - 1));
    @(posedge clk);
    #1;
    chk("len_err", 64'(o_len_err), 64'(exp_err));
    i_FFT_valid = 1'b0;
    i_FFT_last  = 1'b0;
    bidx = (lst || bidx == FFT - 1) ? 0 : bidx + 1;
    if (gaps && $urandom_range(0, 7) == 0) idle(1);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Output monitor
  always @(negedge clk) begin
    exp_t e;
    if (o_rotate_valid === 1'b1) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_I", 64'(o_rotate_I_data), 64'(e.i));
        chk("out_Q", 64'(o_rotate_Q_data), 64'(e.q));
        chk("out_last", 64'(o_rotate_last), 64'(e.last));
        chk("latency", 64'(cyc - e.cyc), 64'(LAT + 3));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; i_mode = 8'd0; i_FFT_valid = 1'b0; i_FFT_last = 1'b0;
    i_FFT_I_data = '0; i_FFT_Q_data = '0;
    idle(3);
    // Reset state
    chk("rst_valid", 64'(o_rotate_valid), 64'd0);
    chk("rst_last", 64'(o_rotate_last), 64'd0);
    chk("rst_I", 64'(o_rotate_I_data), 64'd0);
    chk("rst_Q", 64'(o_rotate_Q_data), 64'd0);
    chk("rst_len_err", 64'(o_len_err), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_addr", 64'(o_ram_rotate_addr), 64'd0);
    rst = 1'b0;
    idle(1);

    // Full frame with identity phasor
    sel = 0; cur_conj = 1'b0; i_mode = 8'd4;
    idle(3);
    chk("busy_work", 64'(o_busy), 64'd1);
    for (int b = 0; b < FFT; b++) beat(rnd16(), rnd16(), b == FFT - 1, 1'b1, 1'b1);
    wait_drain("drain_t1");

    // 90-degree phasor, plain then conjugate
    sel = 1;
    idle(2);
    beat(1000, 0, 1'b0, 1'b1, 1'b0);
    beat(-1234, 567, 1'b1, 1'b1, 1'b0);
    i_mode = 8'd5; cur_conj = 1'b1;
    idle(2);
    beat(1000, 0, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_t2");

    // Saturation
    sel = 2;
    idle(2);
    beat(-32768, 0, 1'b0, 1'b1, 1'b0);
    beat(-32768, -32768, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_t3");
    idle(3);
    chk("hold_I", 64'(o_rotate_I_data), 64'h7fff);
    chk("hold_Q", 64'(o_rotate_Q_data), 64'h7fff);

    // Mode change mid-frame applies from the next frame
    sel = 3; i_mode = 8'd4; cur_conj = 1'b0;
    idle(2);
    for (int b = 0; b < 3; b++) beat(rnd16(), rnd16(), 1'b0, 1'b1, 1'b0);
    i_mode = 8'd5;
    for (int b = 3; b < 6; b++) beat(rnd16(), rnd16(), b == 5, 1'b1, 1'b0);
    cur_conj = 1'b1;
    beat(rnd16(), rnd16(), 1'b0, 1'b1, 1'b0);
    beat(rnd16(), rnd16(), 1'b1, 1'b1, 1'b0);

    // Mode cleared mid-frame: frame completes, then idle
    for (int b = 0; b < 9; b++) beat(rnd16(), rnd16(), 1'b0, 1'b1, 1'b0);
    i_mode = 8'd0;
    idle(1);
    chk("busy_drain", 64'(o_busy), 64'd1);
    for (int b = 9; b < 20; b++) beat(rnd16(), rnd16(), b == 19, 1'b1, 1'b0);
    n = 0;
    while (o_busy !== 1'b0 && n < 40) begin
      idle(1);
      n++;
    end
    chk("busy_drop", 64'(o_busy), 64'd0);
    wait_drain("drain_t5");
    for (int b = 0; b < 4; b++) beat(rnd16(), rnd16(), b == 3, 1'b0, 1'b0);

    // Mode set at beat 100; frame ends at count FFT-1 without last
    for (int b = 0; b < 100; b++) beat(rnd16(), rnd16(), 1'b0, 1'b0, 1'b0);
    i_mode = 8'd4; cur_conj = 1'b0;
    idle(1);
    chk("busy_arm", 64'(o_busy), 64'd1);
    for (int b = 100; b < FFT; b++) beat(rnd16(), rnd16(), 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < FFT; b++) beat(rnd16(), rnd16(), b == FFT - 1, 1'b1, 1'b1);

    // Reset at beat 300
    for (int b = 0; b < 300; b++) beat(rnd16(), rnd16(), 1'b0, 1'b1, 1'b1);
    i_FFT_I_data = 16'h1234; i_FFT_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    chk("mid_rst_valid", 64'(o_rotate_valid), 64'd0);
    chk("mid_rst_last", 64'(o_rotate_last), 64'd0);
    chk("mid_rst_I", 64'(o_rotate_I_data), 64'd0);
    chk("mid_rst_Q", 64'(o_rotate_Q_data), 64'd0);
    chk("mid_rst_len_err", 64'(o_len_err), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_addr", 64'(o_ram_rotate_addr), 64'd0);
    rst = 1'b0; i_FFT_valid = 1'b0; i_mode = 8'd0; bidx = 0;
    idle(10);
    wait_drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
